// File: rtl/calculator_core_if.sv
// rtl/calculator_core_if.sv - switch/operand/result bus between the control front end, calculator_core and the VGA display stage
//
// Signals:
//   sw_data  operand value from the switches
//   load_a   one-cycle strobe: A <= sw_data
//   load_b   one-cycle strobe: B <= sw_data
//   op       00 ADD, 01 SUB, 10 MUL, 11 DIV (sampled with start)
//   start    one-cycle strobe: launch op
//   A, B, C  operand and result registers (to the display stage)
//   flag     error/overflow of the last completed operation
//   busy     high while an iterative operation runs
//   done     one-cycle pulse after C/flag update
// master: the side driving switches/strobes; slave: calculator_core.
interface calculator_core_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] sw_data;
    logic             load_a;
    logic             load_b;
    logic [1:0]       op;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic             flag;
    logic             busy;
    logic             done;

    modport master (
        output sw_data, load_a, load_b, op, start,
        input  A, B, C, flag, busy, done
    );

    modport slave (
        input  sw_data, load_a, load_b, op, start,
        output A, B, C, flag, busy, done
    );
endinterface

// File: rtl/calculator_core.sv
// rtl/calculator_core.sv - operand/result engine: single-cycle ADD/SUB, bit-serial MUL (shift-add) and DIV (restoring)
//
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   bus  calculator_core_if.slave (sw_data/load_a/load_b/op/start in; A/B/C/flag/busy/done out)
module calculator_core #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    calculator_core_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_c;
    logic               r_flag;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;

    // MUL working set: shifting multiplicand, consumed multiplier, running product
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mplier;

    // DIV working set: partial remainder, dividend shifting out / quotient shifting in, divisor
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;

    logic               w_busy;
    logic               w_done;
    logic               w_div_zero;
    logic               w_last;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_prod_next;
    logic [WIDTH:0]     w_rem_shift;
    logic               w_rem_ge;
    logic [WIDTH-1:0]   w_rem_sub;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;

    assign w_div_zero  = (r_b == '0);
    assign w_last      = (r_cnt == LAST_ITER);
    assign w_sum       = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff      = r_a - r_b;
    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);

    // Restoring step: bring the next dividend bit into the remainder, subtract the
    // divisor only when it fits; the fit decision is the next quotient bit.
    assign w_rem_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_rem_ge    = (w_rem_shift >= {1'b0, r_div});
    assign w_rem_sub   = WIDTH'(w_rem_shift - {1'b0, r_div});
    assign w_rem_next  = w_rem_ge ? w_rem_sub : w_rem_shift[WIDTH-1:0];
    assign w_quo_next  = {r_quo[WIDTH-2:0], w_rem_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    // Only MUL and DIV-by-nonzero need iterations
                    if (bus.op[1] && !(bus.op[0] && w_div_zero)) begin
                        w_state_next = COMPUTE;
                    end else begin
                        w_state_next = DONE;
                    end
                end
            end
            COMPUTE: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_flag   <= 1'b0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
        end else begin
            // Operands are frozen while iterating so the display matches the running op
            if (r_state != COMPUTE) begin
                if (bus.load_a) r_a <= bus.sw_data;
                if (bus.load_b) r_b <= bus.sw_data;
            end

            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        unique case (bus.op)
                            2'b00: begin
                                r_c    <= w_sum[WIDTH-1:0];
                                r_flag <= w_sum[WIDTH];
                            end
                            2'b01: begin
                                r_c    <= w_diff;
                                r_flag <= (r_a < r_b);
                            end
                            2'b10: begin
                                r_mcand  <= {{WIDTH{1'b0}}, r_a};
                                r_mplier <= r_b;
                                r_prod   <= '0;
                                r_cnt    <= '0;
                                r_is_div <= 1'b0;
                            end
                            2'b11: begin
                                if (w_div_zero) begin
                                    r_c    <= '1;
                                    r_flag <= 1'b1;
                                end else begin
                                    r_rem    <= '0;
                                    r_quo    <= r_a;
                                    r_div    <= r_b;
                                    r_cnt    <= '0;
                                    r_is_div <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                COMPUTE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        if (w_last) begin
                            r_c    <= w_quo_next;
                            r_flag <= 1'b0;
                        end
                    end else begin
                        r_prod   <= w_prod_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        if (w_last) begin
                            r_c    <= w_prod_next[WIDTH-1:0];
                            r_flag <= |w_prod_next[2*WIDTH-1:WIDTH];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.A    = r_a;
    assign bus.B    = r_b;
    assign bus.C    = r_c;
    assign bus.flag = r_flag;
    assign bus.busy = w_busy;
    assign bus.done = w_done;
endmodule

// File: tb/tb_calculator_core.sv
// tb/tb_calculator_core.sv - directed and randomized checks of calculator_core against an arithmetic reference model
module tb_calculator_core;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    calculator_core_if #(.WIDTH(W)) bus ();
    calculator_core #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_total = 0;
    int n_pass  = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // {flag, C} from plain unsigned arithmetic
    function automatic logic [W:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned x, y, r;
        x = a;
        y = b;
        case (op)
            2'b00: begin r = x + y; return {r > 32'hFFFF, r[W-1:0]}; end
            2'b01: begin r = x - y; return {x < y, r[W-1:0]}; end
            2'b10: begin r = x * y; return {r > 32'hFFFF, r[W-1:0]}; end
            default: begin
                if (y == 0) return {1'b1, 16'hFFFF};
                r = x / y;
                return {1'b0, r[W-1:0]};
            end
        endcase
    endfunction

    // Tasks start and end at posedge+1
    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.sw_data = a; bus.load_a = 1'b1;
        @(posedge clk); #1;
        bus.load_a = 1'b0; bus.sw_data = b; bus.load_b = 1'b1;
        @(posedge clk); #1;
        bus.load_b = 1'b0;
        m_a = a;
        m_b = b;
    endtask

    task automatic wait_done(output bit got, output int nbusy);
        got = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.done) got = 1'b1;
            else if (bus.busy) nbusy++;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input string tag);
        logic [W:0] exp;
        int exp_busy, nbusy;
        bit got;
        exp = model(op, m_a, m_b);
        exp_busy = (op == 2'b10 || (op == 2'b11 && m_b != 0)) ? W : 0;
        bus.op = op; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(got, nbusy);
        check({tag, "_done"}, 32'(got), 32'd1);
        check({tag, "_busy_cycles"}, 32'(nbusy), 32'(exp_busy));
        check({tag, "_C"}, 32'(bus.C), 32'(exp[W-1:0]));
        check({tag, "_flag"}, 32'(bus.flag), 32'(exp[W]));
        check({tag, "_A"}, 32'(bus.A), 32'(m_a));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [W:0] exp;
        bit got;
        int nb, seen;
        logic [1:0] rop;

        rst = 1'b1;
        bus.sw_data = '0; bus.load_a = 1'b0; bus.load_b = 1'b0; bus.op = 2'b00; bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {bus.A, bus.B}, 32'd0);
        check("reset_C", 32'({bus.C, bus.flag, bus.busy, bus.done}), 32'd0);
        @(posedge clk); #1;

        load(16'hFFF0, 16'h0020); run_op(2'b00, "add_carry");
        load(16'd5, 16'd9);       run_op(2'b01, "sub_borrow");
        load(16'd9, 16'd5);       run_op(2'b01, "sub_plain");
        load(16'd255, 16'd257);   run_op(2'b10, "mul_fit");
        load(16'd300, 16'd300);   run_op(2'b10, "mul_ovf");
        load(16'd1000, 16'd7);    run_op(2'b11, "div");
        load(16'd1000, 16'd0);    run_op(2'b11, "div_zero");

        // Both loads together
        bus.sw_data = 16'hA5A5; bus.load_a = 1'b1; bus.load_b = 1'b1;
        @(posedge clk); #1;
        bus.load_a = 1'b0; bus.load_b = 1'b0;
        check("dual_load", {bus.A, bus.B}, 32'hA5A5A5A5);

        // Load in the same cycle as start: operation uses pre-edge A
        load(16'd10, 16'd3);
        bus.sw_data = 16'd100; bus.load_a = 1'b1; bus.op = 2'b00; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.load_a = 1'b0; bus.start = 1'b0;
        wait_done(got, nb);
        check("same_cycle_C", 32'(bus.C), 32'd13);
        check("same_cycle_A", 32'(bus.A), 32'd100);
        m_a = 16'd100;
        @(posedge clk); #1;

        // Start and load during COMPUTE are ignored
        load(16'h0123, 16'h0045);
        exp = model(2'b10, 16'h0123, 16'h0045);
        bus.op = 2'b10; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.sw_data = 16'h1234; bus.load_a = 1'b1; bus.op = 2'b00; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.load_a = 1'b0; bus.start = 1'b0;
        wait_done(got, nb);
        check("ignore_done", 32'(got), 32'd1);
        check("ignore_C", 32'(bus.C), 32'(exp[W-1:0]));
        check("ignore_flag", 32'(bus.flag), 32'(exp[W]));
        check("ignore_A", 32'(bus.A), 32'h0123);
        @(negedge clk);
        check("ignore_no_restart", 32'({bus.busy, bus.done}), 32'd0);
        @(posedge clk); #1;

        // Reset mid-operation
        load(16'd400, 16'd500);
        bus.op = 2'b10; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_AB", {bus.A, bus.B}, 32'd0);
        check("midrst_C", 32'({bus.C, bus.flag, bus.busy, bus.done}), 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        check("midrst_quiet", 32'(seen), 32'd0);
        @(posedge clk); #1;
        load(16'd2, 16'd3); run_op(2'b00, "post_rst_add");

        // Randomized operations against the model
        for (int k = 0; k < 24; k++) begin
            logic [W-1:0] ra, rb;
            int sel;
            rop = 2'($urandom_range(0, 3));
            ra  = W'($urandom);
            sel = $urandom_range(0, 3);
            rb  = (sel == 0) ? '0 : (sel == 1) ? W'($urandom_range(1, 255)) : W'($urandom);
            load(ra, rb);
            run_op(rop, $sformatf("rand%0d_op%0d", k, rop));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
